// File: rtl/status_msg_pkg.sv
// Shared constants and types for the status-line transmitter:
// ASCII bytes of the line format and the FSM state encoding.
package status_msg_pkg;

    localparam logic [7:0] CH_C     = 8'h63;
    localparam logic [7:0] CH_H     = 8'h68;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_IDLE  = 8'hFF;

    typedef enum logic [1:0] {IDLE, CONV, EMIT, DONE} stateT;

    function automatic logic [7:0] bcdToAscii(input logic [3:0] nibble);
        return CH_0 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/status_msg_tx_bin2bcd.sv
// Sequential double-dabble converter: one input bit per cycle, result
// valid (o_valid pulse) FIELD_W cycles after i_load.
module bin2bcd_seq #(
    parameter int FIELD_W = 8,
    parameter int DIGITS  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [FIELD_W-1:0]    i_bin,
    output logic [DIGITS*4-1:0]   o_bcd,
    output logic                  o_valid
);

    localparam int CNT_W = $clog2(FIELD_W + 1);

    logic [FIELD_W-1:0]  binReg;
    logic [DIGITS*4-1:0] bcdReg;
    logic [DIGITS*4-1:0] adjusted;
    logic [CNT_W-1:0]    cnt;
    logic                validReg;

    always_comb begin
        // NOTE: default assignment first so no path leaves the variable unassigned (no latch).
        adjusted = bcdReg;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcdReg[d*4 +: 4] >= 4'd5)
                adjusted[d*4 +: 4] = bcdReg[d*4 +: 4] + 4'd3;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            binReg   <= '0;
            bcdReg   <= '0;
            cnt      <= '0;
            validReg <= 1'b0;
        end else begin
            validReg <= 1'b0;
            if (i_load) begin
                binReg <= i_bin;
                bcdReg <= '0;
                cnt    <= CNT_W'(FIELD_W);
            end else if (cnt != '0) begin
                bcdReg   <= {adjusted[DIGITS*4-2:0], binReg[FIELD_W-1]};
                binReg   <= binReg << 1;
                cnt      <= cnt - CNT_W'(1);
                validReg <= (cnt == CNT_W'(1));
            end
        end
    end

    assign o_bcd   = bcdReg;
    assign o_valid = validReg;

endmodule

// File: rtl/status_msg_tx.sv
// Status-line generator: snapshots NUM_FIELDS values and streams
// "ch<i>:<ddd>" per field (space separated, LF terminated) over valid/ready.
module status_msg_tx
    import status_msg_pkg::*;
#(
    parameter int NUM_FIELDS = 2,
    parameter int FIELD_W    = 8,
    parameter int DIGITS     = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic [NUM_FIELDS*FIELD_W-1:0] i_values,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int K_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int J_W   = $clog2(5 + DIGITS);
    localparam int CMP_W = (FIELD_W > 17) ? FIELD_W : 17;
    localparam logic [K_W-1:0]   LAST_K  = K_W'(NUM_FIELDS - 1);
    localparam logic [J_W-1:0]   LAST_J  = J_W'(4 + DIGITS);
    localparam logic [CMP_W-1:0] MAX_DEC = CMP_W'(10 ** DIGITS - 1);

    stateT                         state, nextState;
    logic [NUM_FIELDS*FIELD_W-1:0] snapshot;
    logic [K_W-1:0]                k;
    logic [J_W-1:0]                j;
    logic [DIGITS*8-1:0]           digitChars;
    logic [DIGITS*8-1:0]           satChars;
    logic                          loadPend;
    logic [FIELD_W-1:0]            curField;
    logic [DIGITS*4-1:0]           bcd;
    logic                          bcdValid;
    logic                          xfer;
    logic                          saturate;
    logic [7:0]                    curByte;

    assign curField = snapshot[int'(k)*FIELD_W +: FIELD_W];
    assign xfer     = (state == EMIT) && i_tx_ready;
    assign saturate = CMP_W'(curField) > MAX_DEC;

    bin2bcd_seq #(
        .FIELD_W (FIELD_W),
        .DIGITS  (DIGITS)
    ) conv (
        .clk     (clk),
        .reset   (reset),
        .i_load  (loadPend),
        .i_bin   (curField),
        .o_bcd   (bcd),
        .o_valid (bcdValid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (i_start && !i_abort) nextState = CONV;
            CONV: if (i_abort) nextState = IDLE;
                  else if (bcdValid) nextState = EMIT;
            EMIT: if (i_abort) nextState = IDLE;
                  else if (xfer && j == LAST_J) nextState = (k == LAST_K) ? DONE : CONV;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        for (int d = 0; d < DIGITS; d++)
            satChars[d*8 +: 8] = saturate ? (CH_0 + 8'd9) : bcdToAscii(bcd[d*4 +: 4]);
    end

    // Converter is kicked one cycle after entering CONV, so it always sees the updated k.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snapshot   <= '0;
            k          <= '0;
            j          <= '0;
            digitChars <= '0;
            loadPend   <= 1'b0;
        end else begin
            loadPend <= (nextState == CONV) && (state != CONV);
            if (state == IDLE && nextState == CONV) begin
                snapshot <= i_values;
                k        <= '0;
                j        <= '0;
            end
            if (state == CONV && bcdValid)
                digitChars <= satChars;
            if (state == EMIT && xfer) begin
                if (j == LAST_J) begin
                    j <= '0;
                    if (k != LAST_K) k <= k + K_W'(1);
                end else begin
                    j <= j + J_W'(1);
                end
            end
            if (nextState == IDLE && state != IDLE) begin
                k <= '0;
                j <= '0;
            end
        end
    end

    always_comb begin
        curByte = CH_IDLE;
        if (j == J_W'(0))       curByte = CH_C;
        else if (j == J_W'(1))  curByte = CH_H;
        else if (j == J_W'(2))  curByte = CH_0 + 8'(k);
        else if (j == J_W'(3))  curByte = CH_COLON;
        else if (j == LAST_J)   curByte = (k == LAST_K) ? CH_LF : CH_SPACE;
        else                    curByte = digitChars[(DIGITS - 1 - (int'(j) - 4))*8 +: 8];
    end

    always_comb begin
        o_tx_valid = (state == EMIT);
        o_tx_data  = (state == EMIT) ? curByte : CH_IDLE;
        o_busy     = (state != IDLE);
        o_done     = (state == DONE);
    end

endmodule

// File: tb/tb_status_msg_tx.sv
// Scoreboard bench for status_msg_tx: expected bytes are queued with each
// request and popped by a monitor on every accepted handshake.
module tb_status_msg_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        startA = 1'b0, abortA = 1'b0, readyA = 1'b1;
    logic [15:0] valuesA = '0;
    logic [7:0]  dataA;
    logic        validA, busyA, doneA;

    logic        startB = 1'b0, abortB = 1'b0, readyB = 1'b1;
    logic [15:0] valuesB = '0;
    logic [7:0]  dataB;
    logic        validB, busyB, doneB;

    status_msg_tx dutA (
        .clk(clk), .reset(reset), .i_start(startA), .i_abort(abortA),
        .i_values(valuesA), .o_tx_data(dataA), .o_tx_valid(validA),
        .i_tx_ready(readyA), .o_busy(busyA), .o_done(doneA)
    );

    status_msg_tx #(.NUM_FIELDS(2), .FIELD_W(8), .DIGITS(2)) dutB (
        .clk(clk), .reset(reset), .i_start(startB), .i_abort(abortB),
        .i_values(valuesB), .o_tx_data(dataB), .o_tx_valid(validB),
        .i_tx_ready(readyB), .o_busy(busyB), .o_done(doneB)
    );

    // "ch0:005 ch1:200\n" and "ch0:99 ch1:99\n"
    logic [7:0] lineA [16] = '{8'h63, 8'h68, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h35, 8'h20,
                               8'h63, 8'h68, 8'h31, 8'h3A, 8'h32, 8'h30, 8'h30, 8'h0A};
    logic [7:0] lineB [14] = '{8'h63, 8'h68, 8'h30, 8'h3A, 8'h39, 8'h39, 8'h20,
                               8'h63, 8'h68, 8'h31, 8'h3A, 8'h39, 8'h39, 8'h0A};

    logic [7:0] expA[$];
    logic [7:0] expB[$];
    int errors = 0;
    int checks = 0;
    int doneCntA = 0, doneCntB = 0, sentA = 0, sentB = 0;
    logic stabEn = 1'b0;
    logic prevValid = 1'b0, prevReady = 1'b0;
    logic [7:0] prevData = 8'hFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (stabEn && prevValid && !prevReady) begin
            check("hold_valid", {31'd0, validA}, 32'd1);
            check("hold_data", {24'd0, dataA}, {24'd0, prevData});
        end
        if (validA && readyA) begin
            checks++;
            if (expA.size() == 0) begin
                errors++;
                $display("FAIL extra_byte_A: got %0h expected no byte", dataA);
            end else begin
                logic [7:0] e;
                e = expA.pop_front();
                checks--;
                check($sformatf("byteA[%0d]", sentA), {24'd0, dataA}, {24'd0, e});
            end
            sentA++;
        end
        if (doneA) doneCntA++;
        prevValid = validA;
        prevReady = readyA;
        prevData  = dataA;
    end

    always @(negedge clk) begin
        if (validB && readyB) begin
            checks++;
            if (expB.size() == 0) begin
                errors++;
                $display("FAIL extra_byte_B: got %0h expected no byte", dataB);
            end else begin
                logic [7:0] e;
                e = expB.pop_front();
                checks--;
                check($sformatf("byteB[%0d]", sentB), {24'd0, dataB}, {24'd0, e});
            end
            sentB++;
        end
        if (doneB) doneCntB++;
    end

    task automatic pushA(input int n);
        for (int i = 0; i < n; i++) expA.push_back(lineA[i]);
    endtask

    task automatic pulseA();
        @(posedge clk); #1 startA = 1'b1;
        @(posedge clk); #1 startA = 1'b0;
    endtask

    task automatic waitDoneA(input string name, input int budget, input bit toggle);
        int c;
        int d0;
        c  = 0;
        d0 = doneCntA;
        while (doneCntA == d0 && c < budget) begin
            @(posedge clk); #1;
            if (toggle) readyA = 1'($urandom_range(0, 1));
            c++;
        end
        check(name, doneCntA, d0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        int d0;
        int s0;
        int quiet;

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", {24'd0, dataA}, 32'hFF);
        check("rst_valid", {31'd0, validA}, 0);
        check("rst_busy", {31'd0, busyA}, 0);
        check("rst_done", {31'd0, doneA}, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Basic line, ready tied high: latency and total timing.
        valuesA = {8'd200, 8'd5};
        pushA(16);
        pulseA();
        n = 0;
        while (!validA && n < 50) begin @(posedge clk); #1; n++; end
        check("first_valid_latency", n, 10);
        while (!doneA && n < 200) begin @(posedge clk); #1; n++; end
        check("done_edge", n, 36);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, doneA}, 0);
        check("busy_after_done", {31'd0, busyA}, 0);
        check("t1_queue_empty", expA.size(), 0);
        check("t1_done_count", doneCntA, 1);

        // Same line under random back-pressure.
        stabEn = 1'b1;
        pushA(16);
        pulseA();
        waitDoneA("t2_done", 800, 1'b1);
        stabEn = 1'b0;
        readyA = 1'b1;
        check("t2_queue_empty", expA.size(), 0);

        // Two-digit instance with saturation.
        valuesB = {8'd99, 8'd255};
        for (int i = 0; i < 14; i++) expB.push_back(lineB[i]);
        @(posedge clk); #1 startB = 1'b1;
        @(posedge clk); #1 startB = 1'b0;
        c = 0;
        while (doneCntB == 0 && c < 200) begin @(posedge clk); #1; c++; end
        check("t3_done", doneCntB, 1);
        check("t3_queue_empty", expB.size(), 0);

        // Snapshot isolation and ignored start while busy.
        valuesA = {8'd200, 8'd5};
        d0 = doneCntA;
        pushA(16);
        pulseA();
        repeat (3) @(posedge clk);
        #1 valuesA = '1;
        repeat (12) @(posedge clk);
        check("t4_busy_mid", {31'd0, busyA}, 1);
        pulseA();
        waitDoneA("t4_done", 200, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("t4_single_done", doneCntA, d0 + 1);
        check("t4_queue_empty", expA.size(), 0);
        check("t4_idle", {31'd0, busyA}, 0);
        valuesA = {8'd200, 8'd5};

        // Abort after the 6th byte.
        d0 = doneCntA;
        s0 = sentA;
        pushA(6);
        pulseA();
        c = 0;
        while (sentA < s0 + 6 && c < 100) begin @(posedge clk); #1; c++; end
        check("t5_six_sent", sentA, s0 + 6);
        abortA = 1'b1;
        readyA = 1'b0;
        @(posedge clk); #1;
        abortA = 1'b0;
        check("t5_valid", {31'd0, validA}, 0);
        check("t5_data", {24'd0, dataA}, 32'hFF);
        check("t5_busy", {31'd0, busyA}, 0);
        readyA = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("t5_no_done", doneCntA, d0);
        check("t5_queue_empty", expA.size(), 0);

        // Full line after abort.
        pushA(16);
        pulseA();
        waitDoneA("t6_done", 200, 1'b0);
        check("t6_queue_empty", expA.size(), 0);

        // Asynchronous reset while presenting a byte.
        readyA = 1'b0;
        d0 = doneCntA;
        pulseA();
        c = 0;
        while (!validA && c < 50) begin @(posedge clk); #1; c++; end
        check("t7_in_emit", {31'd0, validA}, 1);
        #2 reset = 1'b0;
        #1;
        check("t7_data", {24'd0, dataA}, 32'hFF);
        check("t7_valid", {31'd0, validA}, 0);
        check("t7_busy", {31'd0, busyA}, 0);
        check("t7_done", {31'd0, doneA}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        readyA = 1'b1;
        quiet = 0;
        repeat (30) begin @(posedge clk); #1; if (validA) quiet++; end
        check("t7_quiet", quiet, 0);
        check("t7_no_done", doneCntA, d0);

        pushA(16);
        pulseA();
        waitDoneA("t8_done", 200, 1'b0);
        check("t8_queue_empty", expA.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
